// File: rtl/bqs_pkg.sv
// Shared types, constants and the shift rule for the block-floating-point scheduler.
package bqs_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int T_INT8  = 7;
    localparam int T_INT4  = 3;
    localparam int SHIFT_W = 5;

    // Right-shift that brings a value of bit length len under the target magnitude width.
    function automatic logic [SHIFT_W-1:0] shift_from_len(input int len, input logic int4);
        int t;
        int s;
        t = int4 ? T_INT4 : T_INT8;
        s = (len > t) ? (len - t) : 0;
        if (s > 31) s = 31;
        return SHIFT_W'(s);
    endfunction

endpackage

// File: rtl/bqs_lead_one.sv
// Combinational leading-one detector: returns the bit length of val (0 when val is 0).
module bqs_lead_one #(
    parameter int W     = 17,
    parameter int LEN_W = 5
) (
    input  logic [W-1:0]     val,
    output logic [LEN_W-1:0] len
);

    always_comb begin
        len = '0;
        for (int i = 0; i < W; i++) begin
            if (val[i]) len = LEN_W'(i + 1);
        end
    end

endmodule

// File: rtl/blk_quant_sched.sv
// Block-floating-point scheduler: buffers BLK samples, derives one right-shift per block, replays them.
// Optional build macro BQS_FIXED_SHIFT_EN adds a fixed-shift override sampled in CALC.
//
// state | meaning
// FILL  | accept samples into the buffer, track max |x|
// CALC  | one cycle: register the block shift
// DRAIN | replay buffered samples with the shift attached
module blk_quant_sched
    import bqs_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int BLK  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_int4,
`ifdef BQS_FIXED_SHIFT_EN
    input  logic               cfg_fix_en,
    input  logic [SHIFT_W-1:0] cfg_fix_shift,
`endif
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [IN_W-1:0]    s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [IN_W-1:0]    m_data,
    output logic [SHIFT_W-1:0] m_shift,
    output logic               m_int4,
    output logic               m_last
);

    localparam int              IDX_W    = $clog2(BLK);
    localparam int              LEN_W    = $clog2(IN_W + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [IN_W:0]      maxabs, abs_in, sext_in;
    logic [IN_W-1:0]    sample_mem [BLK];
    logic [SHIFT_W-1:0] shift_q, shift_calc;
    logic               int4_q;
    logic [LEN_W-1:0]   len;
    logic               s_acc, m_acc;

    // Magnitude is one bit wider than the sample so the most negative value is exact.
    always_comb begin
        sext_in = {s_data[IN_W-1], s_data};
        abs_in  = s_data[IN_W-1] ? (~sext_in + 1'b1) : sext_in;
    end

    bqs_lead_one #(.W(IN_W + 1), .LEN_W(LEN_W)) u_lead_one (
        .val (maxabs),
        .len (len)
    );

    assign shift_calc = shift_from_len(int'(len), int4_q);
    assign s_acc      = s_valid & s_ready;
    assign m_acc      = m_valid & m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (s_acc && wr_idx == LAST_IDX) state_nxt = CALC;
            CALC:    state_nxt = DRAIN;
            DRAIN:   if (m_acc && rd_idx == LAST_IDX) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        s_ready = (state == FILL) && !rst;
        m_valid = (state == DRAIN);
        m_last  = (state == DRAIN) && (rd_idx == LAST_IDX);
    end

    assign m_data  = sample_mem[rd_idx];
    assign m_shift = shift_q;
    assign m_int4  = int4_q;

    always_ff @(posedge clk) begin
        if (s_acc) sample_mem[wr_idx] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            maxabs  <= '0;
            shift_q <= '0;
            int4_q  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (s_acc) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (abs_in > maxabs) maxabs <= abs_in;
                        if (wr_idx == '0) int4_q <= cfg_int4;
                    end
                end
                CALC: begin
`ifdef BQS_FIXED_SHIFT_EN
                    shift_q <= cfg_fix_en ? cfg_fix_shift : shift_calc;
`else
                    shift_q <= shift_calc;
`endif
                end
                DRAIN: begin
                    if (m_acc) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_idx == LAST_IDX) begin
                            maxabs <= '0;
                            wr_idx <= '0;
                            rd_idx <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blk_quant_sched.sv
// Self-checking bench for blk_quant_sched: directed block table, random blocks vs a reference model.
module tb_blk_quant_sched;

    localparam int IN_W = 16;
    localparam int BLK  = 16;

    typedef logic [IN_W-1:0] blk_t [BLK];

    typedef struct {
        int pat;
        bit int4;
        int rdy;
        bit toggle;
        int exp_shift;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_int4 = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [IN_W-1:0] s_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [IN_W-1:0] m_data;
    logic [4:0]      m_shift;
    logic            m_int4;
    logic            m_last;
`ifdef BQS_FIXED_SHIFT_EN
    logic            cfg_fix_en = 1'b0;
    logic [4:0]      cfg_fix_shift = '0;
`endif

    int errors = 0;
    int checks = 0;

    blk_quant_sched #(.IN_W(IN_W), .BLK(BLK)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_int4      (cfg_int4),
`ifdef BQS_FIXED_SHIFT_EN
        .cfg_fix_en    (cfg_fix_en),
        .cfg_fix_shift (cfg_fix_shift),
`endif
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_shift       (m_shift),
        .m_int4        (m_int4),
        .m_last        (m_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shift: bit length of the largest magnitude, minus the target width.
    function automatic int model_shift(input blk_t d, input bit int4);
        int m, v, a, l, t, s;
        m = 0;
        for (int i = 0; i < BLK; i++) begin
            v = int'($signed(d[i]));
            a = (v < 0) ? -v : v;
            if (a > m) m = a;
        end
        l = $clog2(m + 1);
        t = int4 ? 3 : 7;
        s = (l > t) ? l - t : 0;
        return (s > 31) ? 31 : s;
    endfunction

    function automatic blk_t make_pat(input int p);
        blk_t d;
        for (int i = 0; i < BLK; i++) begin
            case (p)
                0:       d[i] = IN_W'(-100 + 10 * i);
                1:       d[i] = (i == 3) ? IN_W'(1000) : IN_W'(5);
                2:       d[i] = (i == 5) ? 16'h8000 : '0;
                4:       d[i] = (i == 9) ? IN_W'(-127) : IN_W'(127);
                5:       d[i] = (i == 0) ? IN_W'(128) : IN_W'(-3);
                6:       d[i] = (i == BLK - 1) ? 16'h7fff : IN_W'(i);
                default: d[i] = '0;
            endcase
        end
        return d;
    endfunction

    task automatic run_block(input blk_t d, input bit int4, input int rdy_pct,
                             input bit toggle, input int exp_shift, input int abort_at);
        int idx;
        int budget;
        for (int i = 0; i < BLK; i++) begin
            @(negedge clk);
            chk("s_ready_fill", 32'(s_ready), 1);
            if (i == 0) chk("m_valid_fill", 32'(m_valid), 0);
            s_valid  = 1'b1;
            s_data   = d[i];
            cfg_int4 = (toggle && i > 0) ? ~int4 : int4;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = '0;
        chk("calc_m_valid", 32'(m_valid), 0);
        chk("calc_s_ready", 32'(s_ready), 0);
        @(negedge clk);
        chk("latency_m_valid", 32'(m_valid), 1);
        idx    = 0;
        budget = 0;
        while (idx < BLK) begin
            if (idx == abort_at) return;
            m_ready = ($urandom_range(0, 99) < rdy_pct);
            chk("drain_m_valid", 32'(m_valid), 1);
            chk("drain_s_ready", 32'(s_ready), 0);
            chk("m_data", 32'(m_data), 32'(d[idx]));
            chk("m_shift", 32'(m_shift), exp_shift);
            chk("m_int4", 32'(m_int4), 32'(int4));
            chk("m_last", 32'(m_last), (idx == BLK - 1) ? 1 : 0);
            if (m_ready) idx++;
            budget++;
            if (budget > 400) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d outputs expected %0d", idx, BLK);
                return;
            end
            if (idx < BLK) @(negedge clk);
        end
    endtask

    vec_t vecs [11];
    blk_t rd;

    initial begin
        vecs[0]  = '{0, 1'b0, 100, 1'b0, 0};
        vecs[1]  = '{1, 1'b0, 100, 1'b0, 3};
        vecs[2]  = '{1, 1'b1, 100, 1'b0, 7};
        vecs[3]  = '{2, 1'b0, 100, 1'b0, 9};
        vecs[4]  = '{2, 1'b1,  50, 1'b0, 13};
        vecs[5]  = '{3, 1'b0,  50, 1'b0, 0};
        vecs[6]  = '{4, 1'b0,  50, 1'b0, 0};
        vecs[7]  = '{5, 1'b0, 100, 1'b0, 1};
        vecs[8]  = '{6, 1'b1,  50, 1'b0, 12};
        vecs[9]  = '{0, 1'b1, 100, 1'b1, 4};
        vecs[10] = '{1, 1'b0, 100, 1'b1, 3};

        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_shift", 32'(m_shift), 0);
        chk("rst_m_int4", 32'(m_int4), 0);
        rst = 1'b0;

        for (int v = 0; v < 11; v++) begin
            run_block(make_pat(vecs[v].pat), vecs[v].int4, vecs[v].rdy,
                      vecs[v].toggle, vecs[v].exp_shift, -1);
        end

        for (int b = 0; b < 8; b++) begin
            bit ri;
            int mag;
            mag = $urandom_range(0, 15);
            ri  = 1'($urandom_range(0, 1));
            for (int i = 0; i < BLK; i++) begin
                rd[i] = IN_W'($signed(IN_W'($urandom)) >>> ($urandom_range(0, 15) | mag));
            end
            run_block(rd, ri, 50, 1'b0, model_shift(rd, ri), -1);
        end

        // Reset in the middle of replay, then a fresh block.
        run_block(make_pat(1), 1'b1, 100, 1'b0, 7, 7);
        m_ready = 1'b0;
        rst     = 1'b1;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_s_ready", 32'(s_ready), 0);
        chk("midrst_m_last", 32'(m_last), 0);
        chk("midrst_m_shift", 32'(m_shift), 0);
        chk("midrst_m_int4", 32'(m_int4), 0);
        @(negedge clk);
        rst = 1'b0;
        run_block(make_pat(2), 1'b0, 50, 1'b0, 9, -1);

`ifdef BQS_FIXED_SHIFT_EN
        cfg_fix_en    = 1'b1;
        cfg_fix_shift = 5'd4;
        run_block(make_pat(1), 1'b0, 100, 1'b0, 4, -1);
        run_block(make_pat(3), 1'b1, 50, 1'b0, 4, -1);
        cfg_fix_en    = 1'b0;
        run_block(make_pat(1), 1'b0, 100, 1'b0, 3, -1);
`endif

        @(negedge clk);
        m_ready = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
